// File: rtl/prvp_spi_slave_cdc_sync.sv
// prvp_spi_slave_cdc_sync: brings SPI-slave CS, address-valid and control levels into sys_clk,
// detects edges and holds the captured address/rd_wr as a pending request with req/ack and overrun.
module prvp_spi_slave_cdc_sync #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_CTRL       = 2,
    parameter int VALID_EDGE     = 0,
    parameter bit CS_IDLE        = 1'b1
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic [AXI_ADDR_WIDTH-1:0] address,
    input  logic                      address_valid,
    input  logic                      rd_wr,
    input  logic [NUM_CTRL-1:0]       ctrl_in,
    output logic                      cs_sync,
    output logic                      cs_start,
    output logic                      cs_end,
    output logic [NUM_CTRL-1:0]       ctrl_sync,
    output logic                      address_valid_sync,
    output logic [AXI_ADDR_WIDTH-1:0] address_sync,
    output logic                      rd_wr_sync,
    output logic                      req_pending,
    input  logic                      req_ack,
    output logic                      overrun,
    input  logic                      overrun_clr
);
    localparam int W = NUM_CTRL + 2;
    localparam logic [W-1:0] RST_VEC = {{(W-1){1'b0}}, CS_IDLE};
    typedef enum logic {IDLE, PEND} state_t;
    // bit 0 = cs, bit 1 = address_valid, upper bits = ctrl_in
    logic [W-1:0] sv [SYNC_STAGES];
    logic [1:0]   h;
    logic         vs, ev, cap, ovr_set;
    state_t       state, state_n;
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sv[i] <= RST_VEC;
            h <= RST_VEC[1:0];
        end else begin
            sv[0] <= {ctrl_in, address_valid, cs};
            for (int i = 1; i < SYNC_STAGES; i++) sv[i] <= sv[i-1];
            h <= sv[SYNC_STAGES-1][1:0];
        end
    end
    always_comb begin
        cs_sync   = sv[SYNC_STAGES-1][0];
        vs        = sv[SYNC_STAGES-1][1];
        ctrl_sync = sv[SYNC_STAGES-1][W-1:2];
        cs_start  = (cs_sync != h[0]) && (h[0] == CS_IDLE);
        cs_end    = (cs_sync != h[0]) && (cs_sync == CS_IDLE);
        ev        = (VALID_EDGE == 0) ? (vs & ~h[1]) : (VALID_EDGE == 1) ? (~vs & h[1]) : (vs ^ h[1]);
    end
    always_ff @(posedge sys_clk) begin
        state <= rst ? IDLE : state_n;
    end
    // an ack in the same cycle as a new event frees the slot for the new request
    always_comb begin
        cap         = ev && (state == IDLE || req_ack);
        ovr_set     = ev && state == PEND && !req_ack;
        state_n     = cap ? PEND : (state == PEND && req_ack) ? IDLE : state;
        req_pending = state == PEND;
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            address_valid_sync <= 1'b0;
            address_sync       <= '0;
            rd_wr_sync         <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            address_valid_sync <= cap;
            if (cap) begin
                address_sync <= address;
                rd_wr_sync   <= rd_wr;
            end
            overrun <= ovr_set | (overrun & ~overrun_clr);
        end
    end
endmodule

// File: tb/tb_prvp_spi_slave_cdc_sync.sv
// tb_prvp_spi_slave_cdc_sync: two configurations (2 stages/rising, 3 stages/both edges) against
// a model that derives synced levels from an input history and applies the request rules.
module tb_prvp_spi_slave_cdc_sync;
    logic        sys_clk = 1'b0;
    logic        rst = 1'b1, cs = 1'b1, address_valid = 1'b0, rd_wr = 1'b0;
    logic        req_ack = 1'b0, overrun_clr = 1'b0;
    logic [31:0] address = '0;
    logic [1:0]  ctrl_in = '0;
    logic        cs_sync_o [2], cs_start_o [2], cs_end_o [2], avs_o [2], rw_o [2], pend_o [2], ovr_o [2];
    logic [1:0]  ctrl_o [2];
    logic [31:0] addr_o [2];
    int          checks = 0, errors = 0, cyc = -1, last_rst = 0, lat, base;
    int          pcnt [2];
    logic [3:0]  raw_h [0:8191];
    logic        e_pend [2], e_ovr [2], e_pulse [2], e_rw [2], ev [2];
    logic [31:0] e_addr [2];

    always #5 sys_clk = ~sys_clk;

    prvp_spi_slave_cdc_sync #(.AXI_ADDR_WIDTH(32), .SYNC_STAGES(2), .NUM_CTRL(2), .VALID_EDGE(0), .CS_IDLE(1'b1)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .cs(cs), .address(address), .address_valid(address_valid),
        .rd_wr(rd_wr), .ctrl_in(ctrl_in), .cs_sync(cs_sync_o[0]), .cs_start(cs_start_o[0]),
        .cs_end(cs_end_o[0]), .ctrl_sync(ctrl_o[0]), .address_valid_sync(avs_o[0]),
        .address_sync(addr_o[0]), .rd_wr_sync(rw_o[0]), .req_pending(pend_o[0]),
        .req_ack(req_ack), .overrun(ovr_o[0]), .overrun_clr(overrun_clr));

    prvp_spi_slave_cdc_sync #(.AXI_ADDR_WIDTH(32), .SYNC_STAGES(3), .NUM_CTRL(2), .VALID_EDGE(2), .CS_IDLE(1'b1)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .cs(cs), .address(address), .address_valid(address_valid),
        .rd_wr(rd_wr), .ctrl_in(ctrl_in), .cs_sync(cs_sync_o[1]), .cs_start(cs_start_o[1]),
        .cs_end(cs_end_o[1]), .ctrl_sync(ctrl_o[1]), .address_valid_sync(avs_o[1]),
        .address_sync(addr_o[1]), .rd_wr_sync(rw_o[1]), .req_pending(pend_o[1]),
        .req_ack(req_ack), .overrun(ovr_o[1]), .overrun_clr(overrun_clr));

    function automatic int ns(int m);
        return (m == 0) ? 2 : 3;
    endfunction

    // synced {ctrl, valid, cs} after edge e = raw sample taken n-1 edges earlier, idle if a reset intervened
    function automatic logic [3:0] sync_at(int n, int e);
        int k;
        k = e - n + 1;
        return (k < 0 || k <= last_rst) ? 4'b0001 : raw_h[k];
    endfunction

    always @(posedge sys_clk) begin
        logic [3:0] c, p;
        logic       set;
        cyc = cyc + 1;
        raw_h[cyc] = {ctrl_in, address_valid, cs};
        if (rst) last_rst = cyc;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                e_pend[m] = 0; e_ovr[m] = 0; e_pulse[m] = 0; e_rw[m] = 0; e_addr[m] = 0; ev[m] = 0;
            end else begin
                set = 0;
                e_pulse[m] = 0;
                if (ev[m]) begin
                    if (!e_pend[m] || req_ack) begin
                        e_addr[m] = address; e_rw[m] = rd_wr; e_pulse[m] = 1; e_pend[m] = 1;
                    end else set = 1;
                end else if (e_pend[m] && req_ack) e_pend[m] = 0;
                e_ovr[m] = set | (e_ovr[m] & ~overrun_clr);
                c = sync_at(ns(m), cyc);
                p = sync_at(ns(m), cyc - 1);
                ev[m] = (m == 0) ? (c[1] & ~p[1]) : (c[1] ^ p[1]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] c, p;
        for (int m = 0; m < 2; m++) begin
            c = sync_at(ns(m), cyc);
            p = sync_at(ns(m), cyc - 1);
            chk($sformatf("cs_sync[%0d]@%0d", m, cyc), {31'b0, cs_sync_o[m]}, {31'b0, c[0]});
            chk($sformatf("cs_start[%0d]@%0d", m, cyc), {31'b0, cs_start_o[m]}, {31'b0, p[0] & ~c[0]});
            chk($sformatf("cs_end[%0d]@%0d", m, cyc), {31'b0, cs_end_o[m]}, {31'b0, ~p[0] & c[0]});
            chk($sformatf("ctrl_sync[%0d]@%0d", m, cyc), {30'b0, ctrl_o[m]}, {30'b0, c[3:2]});
            chk($sformatf("avs[%0d]@%0d", m, cyc), {31'b0, avs_o[m]}, {31'b0, e_pulse[m]});
            chk($sformatf("addr[%0d]@%0d", m, cyc), addr_o[m], e_addr[m]);
            chk($sformatf("rd_wr[%0d]@%0d", m, cyc), {31'b0, rw_o[m]}, {31'b0, e_rw[m]});
            chk($sformatf("pend[%0d]@%0d", m, cyc), {31'b0, pend_o[m]}, {31'b0, e_pend[m]});
            chk($sformatf("ovr[%0d]@%0d", m, cyc), {31'b0, ovr_o[m]}, {31'b0, e_ovr[m]});
            pcnt[m] += int'(avs_o[m]);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            check_all();
        end
    endtask

    initial begin
        pcnt[0] = 0;
        pcnt[1] = 0;
        tick(3);
        rst = 0;
        // idle after reset release
        tick(20);
        chk("t1_pulses_a", pcnt[0], 0);
        chk("t1_cs_sync_a", {31'b0, cs_sync_o[0]}, 1);
        chk("t1_pend_a", {31'b0, pend_o[0]}, 0);
        // first request, 3-cycle latency on the 2-stage rising-edge instance
        address = 32'hDEAD_BEEF;
        rd_wr = 1;
        address_valid = 1;
        lat = 0;
        do begin tick(); lat++; end while (!avs_o[0] && lat < 10);
        chk("t2_latency", lat, 3);
        chk("t2_addr", addr_o[0], 32'hDEAD_BEEF);
        chk("t2_rw", {31'b0, rw_o[0]}, 1);
        chk("t2_pend", {31'b0, pend_o[0]}, 1);
        // second event without ack is dropped and flagged
        tick(4);
        base = pcnt[0];
        address = 32'h1234_5678;
        rd_wr = 0;
        address_valid = 0;
        tick(4);
        address_valid = 1;
        tick(6);
        chk("t3_ovr", {31'b0, ovr_o[0]}, 1);
        chk("t3_addr_kept", addr_o[0], 32'hDEAD_BEEF);
        chk("t3_no_pulse", pcnt[0] - base, 0);
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        chk("t3_ovr_clr", {31'b0, ovr_o[0]}, 0);
        // ack coincident with the next event
        address_valid = 0;
        tick(4);
        address = 32'hCAFE_0001;
        rd_wr = 1;
        address_valid = 1;
        tick(2);
        req_ack = 1;
        tick();
        req_ack = 0;
        chk("t4_pulse", {31'b0, avs_o[0]}, 1);
        chk("t4_pend", {31'b0, pend_o[0]}, 1);
        chk("t4_addr", addr_o[0], 32'hCAFE_0001);
        chk("t4_ovr", {31'b0, ovr_o[0]}, 0);
        req_ack = 1;
        tick();
        req_ack = 0;
        chk("t4_acked", {31'b0, pend_o[0]}, 0);
        // both-edge instance: one toggle pair with continuous ack gives two pulses
        address_valid = 0;
        tick(10);
        req_ack = 1;
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        base = pcnt[1];
        address_valid = 1;
        tick(8);
        address_valid = 0;
        tick(8);
        req_ack = 0;
        chk("t5_pulses_b", pcnt[1] - base, 2);
        chk("t5_ovr_b", {31'b0, ovr_o[1]}, 0);
        // cs through the 3-stage instance
        cs = 0;
        lat = 0;
        do begin tick(); lat++; end while (!cs_start_o[1] && lat < 10);
        chk("t6_start_lat", lat, 3);
        chk("t6_cs_low", {31'b0, cs_sync_o[1]}, 0);
        tick();
        chk("t6_start_1cyc", {31'b0, cs_start_o[1]}, 0);
        cs = 1;
        lat = 0;
        do begin tick(); lat++; end while (!cs_end_o[1] && lat < 10);
        chk("t6_end_lat", lat, 3);
        tick();
        chk("t6_end_1cyc", {31'b0, cs_end_o[1]}, 0);
        // reset while a request is pending
        address = 32'h0BAD_F00D;
        address_valid = 1;
        tick(5);
        chk("t6_pend_before_rst", {31'b0, pend_o[0]}, 1);
        rst = 1;
        tick(2);
        rst = 0;
        chk("t6_pend_rst", {31'b0, pend_o[0]}, 0);
        tick();
        chk("t6_no_pulse_after_rst", {31'b0, avs_o[0]}, 0);
        tick(6);
        // random traffic, the model checks every cycle
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) begin
                address_valid = ~address_valid;
                address = $urandom;
                rd_wr = 1'($urandom);
            end
            if ($urandom_range(7) == 0) cs = ~cs;
            if ($urandom_range(3) == 0) ctrl_in = 2'($urandom);
            req_ack = ($urandom_range(2) == 0);
            overrun_clr = ($urandom_range(7) == 0);
            rst = (i == 300);
            tick();
        end
        rst = 0;
        req_ack = 0;
        overrun_clr = 0;
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
